// File: rtl/spart_bus_arbiter.sv
// Sole master of the SPART register bus: programs the baud divisor, then
// round-robins two clients onto the bus with rda/tbr-gated data accesses.
module spart_bus_arbiter #(
    parameter logic [15:0] DIV0     = 16'h0516,
    parameter logic [15:0] DIV1     = 16'h028B,
    parameter logic [15:0] DIV2     = 16'h0146,
    parameter logic [15:0] DIV3     = 16'h00A3,
    parameter logic [7:0]  WAIT_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       cfg_reload,
    output logic       cfg_done,
    input  logic       r0_req,
    input  logic       r0_rw,
    input  logic [1:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_gnt,
    output logic       r0_done,
    output logic       r0_err,
    input  logic       r1_req,
    input  logic       r1_rw,
    input  logic [1:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_gnt,
    output logic       r1_done,
    output logic       r1_err,
    output logic [7:0] rdata,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, WAIT, ISSUE, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       cfg_done_q, cfg_done_d;
    logic       reload_q, reload_d;
    logic       prio_q, prio_d;
    logic       cur_q, cur_d;
    logic       rw_q, rw_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [1:0] err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       iocs_q, iocs_d;
    logic       iorw_q, iorw_d;
    logic [1:0] ioaddr_q, ioaddr_d;
    logic [7:0] dout_q, dout_d;

    logic [1:0] elig;
    logic       pick, cur_req, ready;

    function automatic logic [7:0] div_byte(input logic [1:0] s, input logic hi);
        logic [15:0] d;
        case (s)
            2'b00:   d = DIV0;
            2'b01:   d = DIV1;
            2'b10:   d = DIV2;
            default: d = DIV3;
        endcase
        return hi ? d[15:8] : d[7:0];
    endfunction

    always_comb begin
        // A client showing its own done/err pulse is not a fresh request.
        elig    = {r1_req, r0_req} & ~(done_q | err_q);
        pick    = (elig == 2'b11) ? prio_q : elig[1];
        cur_req = cur_q ? r1_req : r0_req;
        ready   = (addr_q != 2'b00) ? 1'b1 : (rw_q ? rda : tbr);

        state_d    = state_q;
        sel_d      = sel_q;
        cfg_done_d = cfg_done_q;
        reload_d   = reload_q | cfg_reload;
        prio_d     = prio_q;
        cur_d      = cur_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;
        iocs_d     = 1'b0;
        iorw_d     = iorw_q;
        ioaddr_d   = ioaddr_q;
        dout_d     = dout_q;

        case (state_q)
            CFG_LO: begin
                sel_d    = br_cfg;
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b10;
                dout_d   = div_byte(br_cfg, 1'b0);
                state_d  = CFG_HI;
            end
            CFG_HI: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b11;
                dout_d     = div_byte(sel_q, 1'b1);
                cfg_done_d = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                gnt_d = 2'b00;
                if (reload_q || cfg_reload) begin
                    reload_d   = 1'b0;
                    cfg_done_d = 1'b0;
                    state_d    = CFG_LO;
                end else if (elig != 2'b00) begin
                    cur_d   = pick;
                    prio_d  = ~pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    rw_d    = pick ? r1_rw : r0_rw;
                    addr_d  = pick ? r1_addr : r0_addr;
                    wdata_d = pick ? r1_wdata : r0_wdata;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!cur_req) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = ISSUE;
                end else if (cnt_q == WAIT_MAX) begin
                    err_d   = cur_q ? 2'b10 : 2'b01;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ISSUE: begin
                iocs_d   = 1'b1;
                iorw_d   = rw_q;
                ioaddr_d = addr_q;
                dout_d   = wdata_q;
                state_d  = DONE;
            end
            DONE: begin
                // The bus cycle is visible this cycle, so read data is sampled here.
                if (rw_q) rdata_d = databus;
                done_d  = cur_q ? 2'b10 : 2'b01;
                state_d = IDLE;
            end
            default: state_d = CFG_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CFG_LO;
            sel_q      <= 2'b00;
            cfg_done_q <= 1'b0;
            reload_q   <= 1'b0;
            prio_q     <= 1'b0;
            cur_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= 2'b00;
            wdata_q    <= 8'h00;
            cnt_q      <= 8'd0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= 8'h00;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= 2'b00;
            dout_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cfg_done_q <= cfg_done_d;
            reload_q   <= reload_d;
            prio_q     <= prio_d;
            cur_q      <= cur_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            dout_q     <= dout_d;
        end
    end

    assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
    assign cfg_done = cfg_done_q;
    assign r0_gnt   = gnt_q[0];
    assign r1_gnt   = gnt_q[1];
    assign r0_done  = done_q[0];
    assign r1_done  = done_q[1];
    assign r0_err   = err_q[0];
    assign r1_err   = err_q[1];
    assign rdata    = rdata_q;
    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Bench for spart_bus_arbiter: a SPART bus model, a scoreboard of expected
// bus cycles, a vector table of single transactions and corner-case sequences.
module tb_spart_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       cfg_reload, cfg_done;
    logic       r0_req, r0_rw, r0_gnt, r0_done, r0_err;
    logic [1:0] r0_addr;
    logic [7:0] r0_wdata;
    logic       r1_req, r1_rw, r1_gnt, r1_done, r1_err;
    logic [1:0] r1_addr;
    logic [7:0] r1_wdata;
    logic [7:0] rdata, sp_data;
    logic       iocs, iorw, rda, tbr;
    logic [1:0] ioaddr;
    wire  [7:0] databus;

    always #5 clk = ~clk;

    assign databus = (iocs && iorw) ? sp_data : 8'hzz;

    spart_bus_arbiter dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .cfg_reload(cfg_reload), .cfg_done(cfg_done),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err),
        .rdata(rdata), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .rda(rda), .tbr(tbr)
    );

    typedef struct packed {
        logic [1:0] addr;
        logic       rw;
        logic [7:0] data;
    } bus_t;

    typedef struct {
        bit         cl;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wd;
        logic [7:0] sd;
        logic [7:0] exp_rd;
        int         lat;
    } vec_t;

    bus_t exp_q[$];
    int   glog[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic g0_prev = 1'b0, g1_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ev: 0 r0_done, 1 r1_done, 2 r0_err, 3 r1_err, 4 cfg_done
    task automatic wait_ev(input int ev, input int max, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < max) begin
            @(negedge clk);
            cyc++;
            case (ev)
                0: hit = r0_done;
                1: hit = r1_done;
                2: hit = r0_err;
                3: hit = r1_err;
                default: hit = cfg_done;
            endcase
        end
        if (!hit) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout_ev%0d: got no event want event within %0d cycles", ev, max);
            cyc = -1;
        end
    endtask

    // Called just after a rising edge; returns one cycle after the done pulse with req dropped.
    task automatic xact(input int c, input logic rw, input logic [1:0] addr,
                        input logic [7:0] wd, input int max, output int lat);
        int cyc;
        if (c == 0) begin
            r0_rw = rw; r0_addr = addr; r0_wdata = wd; r0_req = 1'b1;
        end else begin
            r1_rw = rw; r1_addr = addr; r1_wdata = wd; r1_req = 1'b1;
        end
        wait_ev(c, max, cyc);
        lat = (cyc < 0) ? -1 : cyc - 1;
        tick();
        if (c == 0) r0_req = 1'b0; else r1_req = 1'b0;
    endtask

    always @(negedge clk) begin
        bus_t got, e;
        if (r0_gnt && r1_gnt) begin
            n_chk++;
            n_err++;
            $display("FAIL gnt_onehot: got both grants want at most one");
        end
        if (iocs) begin
            got = {ioaddr, iorw, databus};
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL bus_unexpected: got %h want no bus cycle", got);
            end else begin
                e = exp_q.pop_front();
                chk("bus_cycle", {21'd0, got}, {21'd0, e});
            end
        end
        if (r0_gnt && !g0_prev) glog.push_back(0);
        if (r1_gnt && !g1_prev) glog.push_back(1);
        g0_prev <= r0_gnt;
        g1_prev <= r1_gnt;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   cyc, l0, l1;

        vecs[0] = '{1'b0, 1'b1, 2'b01, 8'h00, 8'h03, 8'h03, 4};
        vecs[1] = '{1'b1, 1'b0, 2'b10, 8'h11, 8'hEE, 8'h03, 4};
        vecs[2] = '{1'b0, 1'b0, 2'b00, 8'hC3, 8'hEE, 8'h03, 4};
        vecs[3] = '{1'b1, 1'b1, 2'b00, 8'h00, 8'hA5, 8'hA5, 4};
        vecs[4] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h7E, 8'h7E, 4};
        vecs[5] = '{1'b0, 1'b0, 2'b01, 8'h00, 8'h99, 8'h7E, 4};

        rst = 1'b0; br_cfg = 2'b01; cfg_reload = 1'b0; sp_data = 8'h00;
        rda = 1'b0; tbr = 1'b0;
        r0_req = 1'b0; r0_rw = 1'b0; r0_addr = 2'b00; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_rw = 1'b0; r1_addr = 2'b00; r1_wdata = 8'h00;
        repeat (3) tick();

        // reset state and initial divisor programming (br_cfg=01)
        chk("rst_iocs", iocs, 0);
        chk("rst_iorw", iorw, 1);
        chk("rst_ioaddr", ioaddr, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
        chk("rst_rdata", rdata, 0);
        exp_q.push_back('{2'b10, 1'b0, 8'h8B});
        exp_q.push_back('{2'b11, 1'b0, 8'h02});
        rst = 1'b1;
        wait_ev(4, 10, cyc);
        chk("cfg_lat", cyc - 1, 2);
        repeat (5) tick();
        chk("cfg_only_two", exp_q.size(), 0);

        // both clients writing data continuously: strict alternation from r0
        tbr = 1'b1;
        glog.delete();
        exp_q.push_back('{2'b00, 1'b0, 8'hA0});
        exp_q.push_back('{2'b00, 1'b0, 8'hB1});
        exp_q.push_back('{2'b00, 1'b0, 8'hA2});
        exp_q.push_back('{2'b00, 1'b0, 8'hB3});
        fork
            begin
                xact(0, 1'b0, 2'b00, 8'hA0, 40, l0);
                tick();
                xact(0, 1'b0, 2'b00, 8'hA2, 40, l0);
            end
            begin
                xact(1, 1'b0, 2'b00, 8'hB1, 40, l1);
                tick();
                xact(1, 1'b0, 2'b00, 8'hB3, 40, l1);
            end
        join
        chk("rr_no_timeout", (l0 > 0) && (l1 > 0), 1);
        chk("rr_grant_count", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("rr_grant_order", glog[i], i % 2);
        repeat (2) tick();

        // r0 data read held off by rda for 10 cycles
        tbr = 1'b0; rda = 1'b0; sp_data = 8'h5A;
        r0_rw = 1'b1; r0_addr = 2'b00; r0_req = 1'b1;
        repeat (10) tick();
        chk("rd_wait_gnt", r0_gnt, 1);
        exp_q.push_back('{2'b00, 1'b1, 8'h5A});
        rda = 1'b1;
        wait_ev(0, 10, cyc);
        chk("rd_rdata", rdata, 8'h5A);
        tick();
        r0_req = 1'b0; rda = 1'b0;
        repeat (2) tick();

        // vector table: single transactions on an idle bus
        rda = 1'b1; tbr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sp_data = vecs[i].sd;
            exp_q.push_back('{vecs[i].addr, vecs[i].rw, vecs[i].rw ? vecs[i].sd : vecs[i].wd});
            xact(int'(vecs[i].cl), vecs[i].rw, vecs[i].addr, vecs[i].wd, 20, l0);
            chk("vec_latency", l0, vecs[i].lat);
            chk("vec_rdata", rdata, vecs[i].exp_rd);
            chk("vec_gnt_dropped", {r1_gnt, r0_gnt}, 0);
            chk("vec_done_pulse", {r1_done, r0_done}, 0);
            repeat (2) tick();
        end
        chk("vec_bus_drained", exp_q.size(), 0);

        // r1 data write with tbr stuck low times out; r0 is served next
        rda = 1'b0; tbr = 1'b0; sp_data = 8'h42;
        glog.delete();
        r1_rw = 1'b0; r1_addr = 2'b00; r1_wdata = 8'h55; r1_req = 1'b1;
        repeat (3) tick();
        r0_rw = 1'b1; r0_addr = 2'b01; r0_req = 1'b1;
        exp_q.push_back('{2'b01, 1'b1, 8'h42});
        wait_ev(3, 300, cyc);
        chk("err_latency", cyc + 2, 257);
        chk("err_gnt_held", {r1_gnt, r0_gnt}, 2'b10);
        tick();
        r1_req = 1'b0;
        wait_ev(0, 20, cyc);
        chk("err_next_r0_lat", cyc, 4);
        chk("err_next_rdata", rdata, 8'h42);
        tick();
        r0_req = 1'b0;
        chk("err_grant_order", (glog.size() == 2) ? {glog[0][7:0], glog[1][7:0]} : 16'hFFFF, 16'h0100);
        repeat (2) tick();

        // cfg_reload during r0 WAIT: r0 finishes, reprogram (br_cfg=11), then r1
        r0_rw = 1'b0; r0_addr = 2'b00; r0_wdata = 8'h77; r0_req = 1'b1;
        repeat (3) tick();
        cfg_reload = 1'b1; br_cfg = 2'b11; sp_data = 8'h9C;
        r1_rw = 1'b1; r1_addr = 2'b01; r1_req = 1'b1;
        tick();
        cfg_reload = 1'b0;
        repeat (2) tick();
        exp_q.push_back('{2'b00, 1'b0, 8'h77});
        exp_q.push_back('{2'b10, 1'b0, 8'hA3});
        exp_q.push_back('{2'b11, 1'b0, 8'h00});
        exp_q.push_back('{2'b01, 1'b1, 8'h9C});
        tbr = 1'b1;
        wait_ev(0, 20, cyc);
        tick();
        r0_req = 1'b0;
        chk("reload_cfg_low", cfg_done, 0);
        wait_ev(1, 40, cyc);
        chk("reload_r1_rdata", rdata, 8'h9C);
        chk("reload_cfg_done", cfg_done, 1);
        chk("reload_order", exp_q.size(), 0);
        tick();
        r1_req = 1'b0;
        repeat (2) tick();

        // reset during the write bus cycle; config re-runs, br_cfg change mid-config ignored
        r0_rw = 1'b0; r0_addr = 2'b01; r0_wdata = 8'hEE; r0_req = 1'b1;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (iocs) begin
                cyc = 1;
                break;
            end
        end
        chk("rst_mid_saw_issue", cyc, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_iocs", iocs, 0);
        chk("rst_mid_iorw", iorw, 1);
        chk("rst_mid_gnt", r0_gnt, 0);
        chk("rst_mid_cfg_done", cfg_done, 0);
        chk("rst_mid_rdata", rdata, 0);
        r0_req = 1'b0; br_cfg = 2'b10;
        exp_q.push_back('{2'b10, 1'b0, 8'h46});
        exp_q.push_back('{2'b11, 1'b0, 8'h01});
        tick();
        rst = 1'b1;
        tick();
        br_cfg = 2'b00;
        wait_ev(4, 10, cyc);
        repeat (5) tick();
        chk("rst_mid_reconfig", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
